execute_muldiv: RTL and testbench
=================================

# execute_muldiv

Iterative multiply/divide unit for the RV32M extension, sitting beside the ALU in the execute stage and fed by the already-forwarded operands. It accepts one M-type operation at a time, holds the pipeline with `out_stall` while it iterates, and returns a single-cycle result pulse to EX/MEM. Datapath width and the number of quotient/product bits retired per cycle are parameters.

## Interface
One clock `clk`; reset `reset` is asynchronous and active-low.

Parameters:
- `XLEN`, default 32: operand/result width.
- `BITS_PER_CYCLE`, default 1: bits retired per iteration, legal values 1, 2 and 4. `XLEN` must be divisible by it, giving `N = XLEN/BITS_PER_CYCLE`.

Ports:
- `clk` input 1: clock, rising edge.
- `reset` input 1: async active-low reset.
- `in_valid` input 1: the M-type instruction currently in ID/EX is valid.
- `in_funct3` input 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `in_operand1`, `in_operand2` input XLEN: post-forwarding rs1/rs2 values.
- `in_rd` input 5: destination register.
- `in_flush` input 1: branch flush; aborts any operation.
- `out_valid` output 1: result valid, one-cycle pulse.
- `out_result` output XLEN: result.
- `out_rd` output 5: rd captured at accept.
- `out_busy` output 1: state is not IDLE.
- `out_stall` output 1: equals `in_valid & ~out_valid & ~in_flush`. It freezes PC, IF/ID and ID/EX.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:** if `in_valid & ~in_flush`, the unit accepts. It latches the operands, funct3 and rd, and computes magnitudes and sign flags.
  - If the op is a divide/remainder with divisor 0, or a signed DIV/REM of `-2^(XLEN-1) / -1`, the next state is DONE (fast path).
  - Otherwise the next state is RUN and the iteration counter is loaded with N-1.
- **RUN:** each cycle retires `BITS_PER_CYCLE` bits.
  - Multiply: shift-add on a 2·XLEN accumulator using operand magnitudes.
  - Divide: restoring division on the magnitudes.
  - When the counter reaches 0, the next state is DONE.
- **DONE:** `out_valid=1` and `out_result` is driven from a register. Next state is IDLE unconditionally. A still-high `in_valid` in this cycle is the same instruction and is not re-accepted.
- Sign rules:
  - MUL and MULH: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - MUL returns the low XLEN bits of the product; MULH, MULHSU and MULHU return the high XLEN bits.
  - The 2·XLEN product is negated when the operand signs differ (signed operands only).
  - Quotient is negated when the signs differ (DIV). Remainder takes the dividend's sign (REM).
- Special results:
  - Divide by zero: quotient all-ones, remainder = dividend.
  - Signed overflow: quotient = dividend, remainder 0.
- Operand inputs are ignored after accept.
- Flush: `in_flush` in any state forces IDLE at the next edge. `out_valid` is suppressed, including in DONE. Flush wins over a simultaneous `in_valid`, so nothing is accepted.
- Async reset (including mid-operation): IDLE; `out_valid`, `out_result`, `out_rd`, `out_busy` and the counter all 0. `out_stall` follows its equation with `out_valid=0`.

## Timing
- Accept at edge T (IDLE, `in_valid` high before edge T).
- RUN occupies cycles T+1…T+N.
- `out_valid` is high during cycle T+N+1. Latency is N+1 cycles from accept, i.e. 33 for XLEN=32, BPC=1 and 9 for BPC=4.
- Fast path: DONE is in cycle T+1.
- `out_stall` is high from the cycle `in_valid` rises until the DONE cycle, where it drops. EX/MEM captures `out_result`/`out_rd` at the end of DONE.
- The next instruction is in ID/EX the cycle after DONE and can be accepted immediately (back-to-back, no bubble).
- `out_busy` is high in RUN and DONE.
- Throughput: one operation per N+2 cycles.

## Test plan
- MUL 7 × 0xFFFFFFFD (XLEN=32, BPC=1): `out_result=0xFFFFFFEB`, `out_valid` exactly 33 cycles after accept, `out_stall` high for 33 cycles, `out_rd` matches.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU the same operands → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD and REM → 0xFFFFFFFF. DIVU 100/7 → 14 and REMU → 2. Repeat with BPC=4: valid 9 cycles after accept.
- DIVU 5/0 → 0xFFFFFFFF, and REMU → 5, both at T+1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0, also at T+1.
- `in_flush` at cycle T+10 of a DIV: IDLE at the next edge with no `out_valid`. A flush coinciding with `in_valid` in IDLE causes no accept. A new MUL issued afterward completes correctly.
- Reset asserted mid-RUN: all outputs 0 immediately (async). After release, a back-to-back MUL then REM each yield correct results with no idle gap between DONE and the next accept.

Source files
------------

// File: rtl/execute_muldiv.sv
// execute_muldiv
//   Iterative RV32M multiply/divide unit for the execute stage. Accepts one
//   M-type operation while idle, iterates BITS_PER_CYCLE bits per cycle on
//   operand magnitudes, then presents a one-cycle result pulse. A divide by zero
//   or a signed overflow takes a one-cycle fast path.
//
//   Parameters
//     XLEN            operand/result width
//     BITS_PER_CYCLE  bits retired per iteration (1, 2 or 4, divides XLEN)
//
//   Ports
//     clk          clock, rising edge
//     reset        asynchronous active-low reset
//     in_valid     M-type instruction valid in ID/EX
//     in_funct3    operation select (MUL..REMU)
//     in_operand1  rs1 value (post-forwarding)
//     in_operand2  rs2 value (post-forwarding)
//     in_rd        destination register
//     in_flush     branch flush, aborts any operation
//     out_valid    one-cycle result pulse
//     out_result   registered result
//     out_rd       destination register captured at accept
//     out_busy     unit is in RUN or DONE
//     out_stall    pipeline hold request
module execute_muldiv #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_operand1,
    input  logic [XLEN-1:0] in_operand2,
    input  logic [4:0]      in_rd,
    input  logic            in_flush,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_busy,
    output logic            out_stall
);

    localparam int unsigned N  = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [4:0]          rd_q, rd_d;
    logic                neg_q, neg_d;
    logic                rem_neg_q, rem_neg_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Accept-time decode of the incoming operands.
    logic                op1_signed, op2_signed;
    logic                s1, s2;
    logic [XLEN-1:0]     mag1, mag2;
    logic                is_div_in;
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     fast_result;

    always_comb begin
        is_div_in  = in_funct3[2];
        // Divides: signed when funct3[0]==0. Multiplies: op1 signed except
        // MULHU, op2 signed only for MUL/MULH.
        op1_signed = is_div_in ? ~in_funct3[0] : (in_funct3[1:0] != 2'b11);
        op2_signed = is_div_in ? ~in_funct3[0] : ~in_funct3[1];
        s1         = op1_signed & in_operand1[XLEN-1];
        s2         = op2_signed & in_operand2[XLEN-1];
        mag1       = s1 ? -in_operand1 : in_operand1;
        mag2       = s2 ? -in_operand2 : in_operand2;
        div_zero   = is_div_in & (in_operand2 == '0);
        div_ovf    = is_div_in & ~in_funct3[0]
                   & (in_operand1 == {1'b1, {(XLEN-1){1'b0}}})
                   & (in_operand2 == '1);
        if (div_zero) begin
            fast_result = in_funct3[1] ? in_operand1 : '1;
        end else begin
            fast_result = in_funct3[1] ? '0 : in_operand1;
        end
    end

    // One iteration step: BITS_PER_CYCLE single-bit shift-add (multiply) or
    // restoring-subtract (divide) steps unrolled. acc holds {hi, lo} for the
    // multiply and {remainder, dividend/quotient} for the divide.
    logic [2*XLEN-1:0]   step_acc;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       rem_sh;
    logic [XLEN-1:0]     rem_sub;

    always_comb begin
        step_acc = acc_q;
        mul_sum  = '0;
        rem_sh   = '0;
        rem_sub  = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (funct3_q[2]) begin
                rem_sh = {step_acc[2*XLEN-1:XLEN], step_acc[XLEN-1]};
                if (rem_sh >= {1'b0, a_q}) begin
                    // Difference is below the divisor, so it fits in XLEN bits.
                    rem_sub  = rem_sh[XLEN-1:0] - a_q;
                    step_acc = {rem_sub, step_acc[XLEN-2:0], 1'b1};
                end else begin
                    step_acc = {rem_sh[XLEN-1:0], step_acc[XLEN-2:0], 1'b0};
                end
            end else begin
                mul_sum  = {1'b0, step_acc[2*XLEN-1:XLEN]}
                         + (step_acc[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
                step_acc = {mul_sum, step_acc[XLEN-1:1]};
            end
        end
    end

    // Sign correction and result selection once the last step is retired.
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rem;
    logic [XLEN-1:0]     fin_result;

    always_comb begin
        prod = neg_q ? -step_acc : step_acc;
        quo  = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
        rem  = rem_neg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
        case (funct3_q)
            3'b000:                 fin_result = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_result = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin_result = quo;
            default:                fin_result = rem;
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        a_d       = a_q;
        funct3_d  = funct3_q;
        rd_d      = rd_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid && !in_flush) begin
                    funct3_d  = in_funct3;
                    rd_d      = in_rd;
                    neg_d     = s1 ^ s2;
                    rem_neg_d = s1;
                    if (div_zero || div_ovf) begin
                        result_d = fast_result;
                        state_d  = DONE;
                    end else begin
                        // Divide: a holds the divisor, acc starts as {0, dividend}.
                        // Multiply: a holds the multiplicand, acc starts as {0, multiplier}.
                        a_d     = is_div_in ? mag2 : mag1;
                        acc_d   = {{XLEN{1'b0}}, (is_div_in ? mag1 : mag2)};
                        cnt_d   = CW'(N - 1);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = step_acc;
                if (cnt_q == '0) begin
                    result_d = fin_result;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (in_flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            funct3_q  <= funct3_d;
            rd_q      <= rd_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        out_valid  = (state_q == DONE) && !in_flush;
        out_result = result_q;
        out_rd     = rd_q;
        out_busy   = (state_q != IDLE);
        out_stall  = in_valid & ~out_valid & ~in_flush;
    end

endmodule

// File: tb/tb_execute_muldiv.sv
module tb_execute_muldiv;

    logic        clk;
    logic        reset;
    logic        v1, v4;
    logic [2:0]  f3_i;
    logic [31:0] op1, op2;
    logic [4:0]  rd_i;
    logic        in_flush;

    logic        ov1, busy1, stall1;
    logic [31:0] res1;
    logic [4:0]  rd1;
    logic        ov4, busy4, stall4;
    logic [31:0] res4;
    logic [4:0]  rd4;

    execute_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_funct3(f3_i),
        .in_operand1(op1), .in_operand2(op2), .in_rd(rd_i), .in_flush(in_flush),
        .out_valid(ov1), .out_result(res1), .out_rd(rd1),
        .out_busy(busy1), .out_stall(stall1)
    );

    execute_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(v4), .in_funct3(f3_i),
        .in_operand1(op1), .in_operand2(op2), .in_rd(rd_i), .in_flush(in_flush),
        .out_valid(ov4), .out_result(res4), .out_rd(rd4),
        .out_busy(busy4), .out_stall(stall4)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
        int          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   stall_cnt[2];
    logic to_flag = 1'b0;
    logic tb_done = 1'b0;
    logic rst_chk = 1'b0;
    logic prev_flush = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    function automatic void chk(input string nm, input int d,
                                input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %h, required %h", nm, d, act, exp);
        end
    endfunction

    // Monitor / scoreboard
    logic        m_ov, m_busy, m_stall, m_iv;
    logic [31:0] m_res;
    logic [4:0]  m_rd;
    exp_t        m_e;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_ov    = (d == 0) ? ov1    : ov4;
            m_busy  = (d == 0) ? busy1  : busy4;
            m_stall = (d == 0) ? stall1 : stall4;
            m_iv    = (d == 0) ? v1     : v4;
            m_res   = (d == 0) ? res1   : res4;
            m_rd    = (d == 0) ? rd1    : rd4;
            if (!reset) begin
                if (!rst_chk) begin
                    chk("rst_valid",  d, {31'b0, m_ov},   32'd0);
                    chk("rst_result", d, m_res,           32'd0);
                    chk("rst_rd",     d, {27'b0, m_rd},   32'd0);
                    chk("rst_busy",   d, {31'b0, m_busy}, 32'd0);
                    chk("rst_stall",  d, {31'b0, m_stall}, {31'b0, m_iv & ~in_flush});
                end
                stall_cnt[d] = 0;
            end else begin
                if (prev_flush) chk("flush_idle", d, {31'b0, m_busy}, 32'd0);
                if (m_ov) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_valid dut%0d: got valid with result %h, required no valid", d, m_res);
                    end else begin
                        if (d == 0) m_e = q0.pop_front();
                        else        m_e = q1.pop_front();
                        chk("result",  d, m_res, m_e.res);
                        chk("rd",      d, {27'b0, m_rd}, {27'b0, m_e.rd});
                        chk("latency", d, cyc, m_e.due);
                        chk("stall",   d, stall_cnt[d], m_e.lat);
                    end
                    stall_cnt[d] = 0;
                end else if (m_stall) begin
                    stall_cnt[d]++;
                end
                if (in_flush) stall_cnt[d] = 0;
            end
        end
        rst_chk    = !reset;
        prev_flush = in_flush && reset;
        if (tb_done) begin
            chk("queue0_empty", 0, q0.size(), 32'd0);
            chk("queue1_empty", 1, q1.size(), 32'd0);
            chk("no_timeout",   0, {31'b0, to_flag}, 32'd0);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    // Driver: must be entered shortly after a rising edge.
    task automatic issue(input int d, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int lat);
        exp_t e;
        logic seen;
        e.res = exp;
        e.rd  = rd;
        e.due = cyc + lat;
        e.lat = lat;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        f3_i = f3;
        op1  = a;
        op2  = b;
        rd_i = rd;
        if (d == 0) v1 = 1'b1;
        else        v4 = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if ((d == 0) ? ov1 : ov4) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) to_flag = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        v4 = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        v1       = 1'b0;
        v4       = 1'b0;
        f3_i     = 3'b000;
        op1      = '0;
        op2      = '0;
        rd_i     = '0;
        in_flush = 1'b0;
        stall_cnt[0] = 0;
        stall_cnt[1] = 0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        // BPC=1, back-to-back
        issue(0, 3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33);
        issue(0, 3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 33);
        issue(0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF, 33);
        issue(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, 33);
        issue(0, 3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 33);
        issue(0, 3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 33);
        issue(0, 3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       33);
        issue(0, 3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        33);
        // Fast paths
        issue(0, 3'b101, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1);
        issue(0, 3'b111, 32'd5,        32'd0,        5'd14, 32'd5,        1);
        issue(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
        issue(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1);

        // BPC=4
        issue(1, 3'b100, 32'hFFFFFFF9, 32'd2,        5'd17, 32'hFFFFFFFD, 9);
        issue(1, 3'b110, 32'hFFFFFFF9, 32'd2,        5'd18, 32'hFFFFFFFF, 9);
        issue(1, 3'b101, 32'd100,      32'd7,        5'd19, 32'd14,       9);
        issue(1, 3'b111, 32'd100,      32'd7,        5'd20, 32'd2,        9);
        issue(1, 3'b000, 32'd7,        32'hFFFFFFFD, 5'd21, 32'hFFFFFFEB, 9);

        // Flush mid-DIV at T+10
        f3_i = 3'b100; op1 = 32'd1000; op2 = 32'd3; rd_i = 5'd22; v1 = 1'b1;
        repeat (10) @(posedge clk);
        #1 in_flush = 1'b1;
        @(posedge clk);
        #1 in_flush = 1'b0; v1 = 1'b0;
        @(posedge clk);
        #1;
        // Flush coinciding with in_valid while idle
        f3_i = 3'b000; op1 = 32'd3; op2 = 32'd3; rd_i = 5'd23; v1 = 1'b1; in_flush = 1'b1;
        @(posedge clk);
        #1 in_flush = 1'b0; v1 = 1'b0;
        @(posedge clk);
        #1;
        issue(0, 3'b000, 32'd123,      32'd456,      5'd24, 32'h0000DB18, 33);

        // Async reset mid-RUN
        f3_i = 3'b000; op1 = 32'd9; op2 = 32'd9; rd_i = 5'd25; v1 = 1'b1;
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1 v1 = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        issue(0, 3'b000, 32'h0000FFFF, 32'h00010001, 5'd26, 32'hFFFFFFFF, 33);
        issue(0, 3'b110, 32'hFFFFFF9C, 32'd7,        5'd27, 32'hFFFFFFFE, 33);

        repeat (2) @(posedge clk);
        #1 tb_done = 1'b1;
    end

endmodule
